temp_sample_proc: RTL and testbench

//  Downstream post-processor for the ADT7420 I2C temperature reader. Takes each raw 16-bit
//  {msb,lsb} word the reader delivers and converts it to signed 1/16 degC. Keeps a 2^AVG_LOG2

---
 rtl/temp_sample_proc.sv | 165 ++++++++++++++++
 tb/tb_temp_sample_proc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_proc.sv
// Post-processor for raw ADT7420 words: 1/16 degC conversion, moving average,
// min/max tracking, over-temperature alarm with hysteresis and 0.1 degC display value.
module temp_sample_proc #(
    parameter int AVG_LOG2   = 3,
    parameter int ALARM_HI   = 480,
    parameter int ALARM_HYST = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_raw,
    input  logic        clear_minmax,
    output logic [12:0] temp_now,
    output logic [12:0] temp_avg,
    output logic [12:0] temp_min,
    output logic [12:0] temp_max,
    output logic        avg_valid,
    output logic        alarm,
    output logic [15:0] disp_tenths,
    output logic        disp_neg,
    output logic        out_valid
);

    localparam int DATA_W = 13;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;

    localparam logic signed [DATA_W-1:0] SET_T = DATA_W'(ALARM_HI);
    localparam logic signed [DATA_W-1:0] CLR_T = DATA_W'(ALARM_HI - ALARM_HYST);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, CONVERT} state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  ring [DEPTH];
    logic [AVG_LOG2-1:0]       wr_ptr;
    logic [CNT_W-1:0]          fill;
    logic signed [SUM_W-1:0]   sum;
    logic                      mm_empty;
    logic                      clr_pend;
    logic signed [DATA_W-1:0]  now_r;
    logic signed [DATA_W-1:0]  avg_r;
    logic signed [DATA_W-1:0]  min_r;
    logic signed [DATA_W-1:0]  max_r;

    logic signed [DATA_W-1:0]  oldest;
    logic signed [SUM_W-1:0]   sum_next;
    logic signed [SUM_W-1:0]   sum_shr;
    logic signed [DATA_W-1:0]  avg_calc;
    logic                      unused_lsbs;

    function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [DATA_W-1:0] v);
        return {{AVG_LOG2{v[DATA_W-1]}}, v};
    endfunction

    // |v| widened to 17 bits so -4096 does not wrap, then scaled 10/16 with truncation.
    function automatic logic [15:0] to_tenths(input logic signed [DATA_W-1:0] v);
        logic signed [16:0] w;
        logic [16:0]        m;
        logic [20:0]        p;
        w = {{(17-DATA_W){v[DATA_W-1]}}, v};
        m = w[16] ? 17'(-w) : 17'(w);
        p = 21'(m) * 21'd10;
        return p[19:4];
    endfunction

    function automatic logic signed [DATA_W-1:0] min_of(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] max_of(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign unused_lsbs = ^sample_raw[2:0];

    // Once the window is full the slot about to be overwritten holds the oldest sample.
    assign oldest   = (fill == CNT_W'(DEPTH)) ? ring[wr_ptr] : '0;
    assign sum_next = sum + sext_sum(now_r) - sext_sum(oldest);
    assign sum_shr  = sum >>> AVG_LOG2;
    assign avg_calc = avg_valid ? sum_shr[DATA_W-1:0] : now_r;

    assign temp_now = now_r;
    assign temp_avg = avg_r;
    assign temp_min = min_r;
    assign temp_max = max_r;

    always_ff @(posedge clk) begin
        if (state == ACCUM) begin
            ring[wr_ptr] <= now_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            mm_empty    <= 1'b1;
            clr_pend    <= 1'b0;
            now_r       <= '0;
            avg_r       <= '0;
            min_r       <= '0;
            max_r       <= '0;
            avg_valid   <= 1'b0;
            alarm       <= 1'b0;
            disp_tenths <= '0;
            disp_neg    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear_minmax) begin
                clr_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        now_r <= $signed(sample_raw[15:3]);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum    <= sum_next;
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != CNT_W'(DEPTH)) begin
                        fill <= fill + 1'b1;
                    end
                    avg_valid <= (fill >= CNT_W'(DEPTH - 1));
                    state     <= UPDATE;
                end
                UPDATE: begin
                    avg_r <= avg_calc;
                    if (mm_empty || clr_pend || clear_minmax) begin
                        min_r <= now_r;
                        max_r <= now_r;
                    end else begin
                        min_r <= min_of(min_r, now_r);
                        max_r <= max_of(max_r, now_r);
                    end
                    mm_empty <= 1'b0;
                    clr_pend <= 1'b0;
                    if (avg_valid) begin
                        if (avg_calc >= SET_T) begin
                            alarm <= 1'b1;
                        end else if (avg_calc < CLR_T) begin
                            alarm <= 1'b0;
                        end
                    end
                    state <= CONVERT;
                end
                CONVERT: begin
                    disp_tenths <= to_tenths(avg_r);
                    disp_neg    <= avg_r[DATA_W-1];
                    out_valid   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sample_proc.sv
// Directed self-checking bench for temp_sample_proc with hand-computed expectations.
module tb_temp_sample_proc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_valid;
    logic [15:0]        sample_raw;
    logic               clear_minmax;
    logic signed [12:0] temp_now;
    logic signed [12:0] temp_avg;
    logic signed [12:0] temp_min;
    logic signed [12:0] temp_max;
    logic               avg_valid;
    logic               alarm;
    logic [15:0]        disp_tenths;
    logic               disp_neg;
    logic               out_valid;

    int vectors     = 0;
    int miscompares = 0;

    temp_sample_proc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_raw   (sample_raw),
        .clear_minmax (clear_minmax),
        .temp_now     (temp_now),
        .temp_avg     (temp_avg),
        .temp_min     (temp_min),
        .temp_max     (temp_max),
        .avg_valid    (avg_valid),
        .alarm        (alarm),
        .disp_tenths  (disp_tenths),
        .disp_neg     (disp_neg),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_now"}, temp_now, 0);
        chk({tag, "_avg"}, temp_avg, 0);
        chk({tag, "_min"}, temp_min, 0);
        chk({tag, "_max"}, temp_max, 0);
        chk({tag, "_avgv"}, avg_valid, 0);
        chk({tag, "_alarm"}, alarm, 0);
        chk({tag, "_tenths"}, disp_tenths, 0);
        chk({tag, "_neg"}, disp_neg, 0);
        chk({tag, "_outv"}, out_valid, 0);
    endtask

    function automatic logic [15:0] raw_of(input int t);
        return 16'(t * 8);
    endfunction

    // Returns at the negedge where out_valid is high; bounded wait.
    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic send(input int t);
        @(negedge clk);
        sample_raw   = raw_of(t);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int avg447 [8] = '{458, 456, 455, 453, 451, 450, 448, 447};
    int avg470 [8] = '{449, 452, 455, 458, 461, 464, 467, 470};

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_raw   = '0;
        clear_minmax = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Fill the window at 30.0 degC
        for (int i = 0; i < 8; i++) begin
            send(480);
            chk("t1_avg", temp_avg, 480);
            chk("t1_avg_valid", avg_valid, (i == 7) ? 1 : 0);
            chk("t1_alarm", alarm, (i == 7) ? 1 : 0);
        end
        chk("t1_tenths", disp_tenths, 300);
        chk("t1_neg", disp_neg, 0);

        // Hysteresis walk
        for (int i = 0; i < 8; i++) begin
            send(460);
            chk("t3_alarm_460", alarm, 1);
        end
        chk("t3_avg_460", temp_avg, 460);
        for (int i = 0; i < 8; i++) begin
            send(447);
            chk("t3_avg_447", temp_avg, avg447[i]);
            chk("t3_alarm_447", alarm, (i == 7) ? 0 : 1);
        end
        for (int i = 0; i < 8; i++) begin
            send(470);
            chk("t3_avg_470", temp_avg, avg470[i]);
            chk("t3_alarm_470", alarm, 0);
        end

        // Negative sample before the window fills
        do_reset();
        send(-16);
        chk("t2_now", temp_now, -16);
        chk("t2_avg", temp_avg, -16);
        chk("t2_neg", disp_neg, 1);
        chk("t2_tenths", disp_tenths, 10);
        chk("t2_avg_valid", avg_valid, 0);

        // Min/max tracking and clear
        send(100);
        send(-50);
        send(300);
        chk("t4_min", temp_min, -50);
        chk("t4_max", temp_max, 300);
        @(negedge clk);
        clear_minmax = 1'b1;
        @(negedge clk);
        clear_minmax = 1'b0;
        send(20);
        chk("t4_clr_min", temp_min, 20);
        chk("t4_clr_max", temp_max, 20);
        send(10);
        chk("t4_after_min", temp_min, 10);
        chk("t4_after_max", temp_max, 20);

        // Strobes while busy are dropped
        @(negedge clk);
        sample_raw   = raw_of(200);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_raw   = raw_of(-300);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_early_outv", out_valid, 0);
        sample_valid = 1'b1;
        @(negedge clk);
        chk("t5_outv", out_valid, 1);
        chk("t5_now_first", temp_now, 200);
        sample_raw = raw_of(-40);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t5_outv_single", out_valid, 0);
        chk("t5_now_e4", temp_now, -40);
        wait_out();
        chk("t5_now_done", temp_now, -40);
        @(negedge clk);
        chk("t5_outv_end", out_valid, 0);

        // Reset during UPDATE
        @(negedge clk);
        sample_raw   = raw_of(77);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("t6_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_outv", out_valid, 0);
        send(16);
        chk("t6_now", temp_now, 16);
        chk("t6_avg", temp_avg, 16);
        chk("t6_avg_valid", avg_valid, 0);
        chk("t6_tenths", disp_tenths, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
